// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access-size and FSM encodings,
// the latched request record, and the size-to-byte-count helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    size_e       size;
    logic [63:0] wdata;
  } req_t;

  function automatic logic [3:0] size_bytes(input size_e sz);
    case (sz)
      SZ_B:    size_bytes = 4'd1;
      SZ_H:    size_bytes = 4'd2;
      SZ_W:    size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// DEPTH_BYTES x 8 storage: 8-lane byte-enabled write, combinational 8-byte
// little-endian read; lane addresses wrap modulo DEPTH_BYTES.
module dmem_byte_array #(
  parameter int DEPTH_BYTES = 512
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_BYTES)-1:0] base,
  input  logic [7:0]                     wen,
  input  logic [63:0]                    wdata,
  output logic [63:0]                    rdata
);
  localparam int AW = $clog2(DEPTH_BYTES);

  // Contents are deliberately not reset.
  logic [7:0] mem [DEPTH_BYTES];

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[base + AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (wen[i]) begin
        mem[base + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one request at a time, executed LATENCY cycles after acceptance.
// Response held until resp_ready; no new request accepted until the cycle after the handshake.
// DMEM_ALIGN_CHECK_EN: when defined, misaligned accesses are rejected with resp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          req_q, req_d, exec;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [3:0]    nbytes;
  logic [7:0]    lane_en, wen;
  logic          range_err, align_err, exec_err, enter_resp;
  logic [63:0]   arr_rdata, load_data;

  // With LATENCY==1 execution happens on the accepting edge, so it must see the live request.
  always_comb begin
    exec = req_q;
    if (state_q == IDLE) begin
      exec.write = req_write;
      exec.addr  = req_addr;
      exec.size  = size_e'(req_size);
      exec.wdata = req_wdata;
    end
  end

  assign nbytes    = size_bytes(exec.size);
  assign range_err = ({1'b0, exec.addr} + 65'(nbytes)) > 65'(DEPTH_BYTES);
  assign lane_en   = 8'((9'd1 << nbytes) - 9'd1);

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = (exec.addr[2:0] & (nbytes[2:0] - 3'd1)) != 3'd0;
`else
  assign align_err = 1'b0;
`endif

  assign exec_err = range_err | align_err;

  always_comb begin
    load_data = '0;
    for (int i = 0; i < 8; i++) begin
      load_data[8*i +: 8] = lane_en[i] ? arr_rdata[8*i +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d = exec;
          cnt_d = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d   = exec_err;
      rdata_d = (exec_err || exec.write) ? 64'h0 : load_data;
    end
  end

  // Memory side effect happens only on the edge entering RESP, so an abandoned store never lands.
  assign wen = {8{enter_resp & exec.write & ~exec_err}} & lane_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  dmem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_array (
    .clk   (clk),
    .base  (exec.addr[AW-1:0]),
    .wen   (wen),
    .wdata (exec.wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written stall/reset sequences,
// and randomized traffic against a byte-array reference model.
module tb_dmem_responder;
  localparam int DEPTH = 512;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] mem_m [DEPTH];

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [1:0]  s;
    logic [63:0] wd;
    logic [63:0] er;
    logic        ee;
  } vec_t;

  vec_t tbl [15];

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: range check on the unbounded address, optional alignment check, byte-wise access.
  function automatic void model(input logic w, input logic [63:0] a, input logic [1:0] s,
                                input logic [63:0] wd, output logic [63:0] rd, output logic e);
    logic [63:0] n;
    n  = 64'd1 << s;
    e  = a > (64'(DEPTH) - n);
`ifdef DMEM_ALIGN_CHECK_EN
    if ((a % n) != 0) e = 1'b1;
`endif
    rd = '0;
    if (!e) begin
      for (int i = 0; i < int'(n); i++) begin
        if (w) mem_m[int'(a) + i] = wd[8*i +: 8];
        else   rd[8*i +: 8] = mem_m[int'(a) + i];
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic xact(input logic w, input logic [63:0] a, input logic [1:0] s,
                      input logic [63:0] wd, input int stall,
                      output logic [63:0] rd, output logic e, output int lat);
    int guard;
    rd  = '0;
    e   = 1'b1;
    lat = -1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_checks++; n_err++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      return;
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_size   = s;
    req_wdata  = wd;
    resp_ready = (stall == 0);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      n_checks++; n_err++;
      $display("FAIL resp_valid_timeout: got 0 expected 1");
      resp_ready = 1'b1;
      return;
    end
    rd = resp_rdata;
    e  = resp_err;
    for (int k = 0; k < stall; k++) begin
      if (k == stall - 1) resp_ready = 1'b1;
      @(negedge clk);
      if (k != stall - 1) begin
        chk("stall_valid", 64'(resp_valid), 64'd1);
        chk("stall_rdata", resp_rdata, rd);
        chk("stall_err", 64'(resp_err), 64'(e));
        chk("stall_req_ready", 64'(req_ready), 64'd0);
      end
    end
    if (stall == 0) @(negedge clk);
    chk("post_hs_valid", 64'(resp_valid), 64'd0);
    chk("post_hs_req_ready", 64'(req_ready), 64'd1);
    resp_ready = 1'b1;
  endtask

  initial begin
    logic [63:0] rd, er;
    logic        e, ee;
    int          lat;

    tbl[0]  = '{1'b1, 64'h10,  2'b11, 64'h1122334455667788, 64'h0, 1'b0};
    tbl[1]  = '{1'b0, 64'h10,  2'b11, 64'h0, 64'h1122334455667788, 1'b0};
    tbl[2]  = '{1'b0, 64'h12,  2'b00, 64'h0, 64'h66, 1'b0};
    tbl[3]  = '{1'b0, 64'h14,  2'b01, 64'h0, 64'h3344, 1'b0};
    tbl[4]  = '{1'b0, 64'h10,  2'b10, 64'h0, 64'h55667788, 1'b0};
    tbl[5]  = '{1'b0, 64'h1FC, 2'b11, 64'h0, 64'h0, 1'b1};
    tbl[6]  = '{1'b1, 64'h1FC, 2'b10, 64'hAABBCCDD, 64'h0, 1'b0};
    tbl[7]  = '{1'b0, 64'h1FC, 2'b10, 64'h0, 64'hAABBCCDD, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
    tbl[8]  = '{1'b0, 64'h12,  2'b10, 64'h0, 64'h0, 1'b1};
`else
    tbl[8]  = '{1'b0, 64'h12,  2'b10, 64'h0, 64'h33445566, 1'b0};
`endif
    tbl[9]  = '{1'b1, 64'h1FF, 2'b00, 64'hFFFFFFFFFFFFFF5A, 64'h0, 1'b0};
    tbl[10] = '{1'b0, 64'h1FE, 2'b01, 64'h0, 64'h5ABB, 1'b0};
    tbl[11] = '{1'b0, 64'h1FF, 2'b01, 64'h0, 64'h0, 1'b1};
    tbl[12] = '{1'b1, 64'hFFFFFFFFFFFFFFF8, 2'b11, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b1};
    tbl[13] = '{1'b0, 64'h1FC, 2'b10, 64'h0, 64'h5ABBCCDD, 1'b0};
    tbl[14] = '{1'b0, 64'h1F8, 2'b11, 64'h0, 64'h5ABBCCDD00000000, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = 2'b00; req_wdata = '0; resp_ready = 1'b1;

    // Reset values, during and right after reset.
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", resp_rdata, 64'h0);
    chk("rst_err", 64'(resp_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    chk("idle_resp_valid", 64'(resp_valid), 64'd0);

    // Give the array defined contents (all zero).
    for (int a = 0; a < DEPTH; a += 8) begin
      model(1'b1, 64'(a), 2'b11, 64'h0, er, ee);
      xact(1'b1, 64'(a), 2'b11, 64'h0, 0, rd, e, lat);
      chk("init_err", 64'(e), 64'd0);
    end

    for (int i = 0; i < 15; i++) begin
      model(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].wd, er, ee);
      xact(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].wd, 0, rd, e, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].er);
      chk($sformatf("vec%0d_err", i), 64'(e), 64'(tbl[i].ee));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
    end

    // Held response with a second request waiting behind it.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_size = 2'b11; resp_ready = 1'b0;
    @(negedge clk);
    req_write = 1'b1; req_addr = 64'h30; req_size = 2'b00; req_wdata = 64'hEE;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_rdata", resp_rdata, 64'h1122334455667788);
      chk("hold_err", 64'(resp_err), 64'd0);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      if (k == 4) resp_ready = 1'b1;
      @(negedge clk);
    end
    chk("hold_hs_valid", 64'(resp_valid), 64'd0);
    chk("hold_hs_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    chk("second_accepted", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("second_valid", 64'(resp_valid), 64'd1);
    chk("second_rdata", resp_rdata, 64'h0);
    chk("second_err", 64'(resp_err), 64'd0);
    model(1'b1, 64'h30, 2'b00, 64'hEE, er, ee);
    @(negedge clk);
    xact(1'b0, 64'h30, 2'b00, 64'h0, 0, rd, e, lat);
    chk("second_store_seen", rd, 64'hEE);

    // Reset in WAIT abandons the store; an earlier committed store survives.
    model(1'b1, 64'h21, 2'b00, 64'h99, er, ee);
    xact(1'b1, 64'h21, 2'b00, 64'h99, 0, rd, e, lat);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_size = 2'b00; req_wdata = 64'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wait_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_rdata", resp_rdata, 64'h0);
    chk("midrst_err", 64'(resp_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact(1'b0, 64'h20, 2'b00, 64'h0, 0, rd, e, lat);
    chk("abandoned_store", rd, 64'h00);
    xact(1'b0, 64'h21, 2'b00, 64'h0, 0, rd, e, lat);
    chk("committed_store", rd, 64'h99);

    // Randomized traffic against the model.
    for (int t = 0; t < 300; t++) begin
      logic        w;
      logic [1:0]  s;
      logic [63:0] a, wd;
      int          stall;
      w     = 1'($urandom_range(0, 1));
      s     = 2'($urandom_range(0, 3));
      a     = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, DEPTH + 8));
      wd    = {$urandom, $urandom};
      stall = $urandom_range(0, 2);
      model(w, a, s, wd, er, ee);
      xact(w, a, s, wd, stall, rd, e, lat);
      chk($sformatf("rnd%0d_rdata", t), rd, er);
      chk($sformatf("rnd%0d_err", t), 64'(e), 64'(ee));
      chk($sformatf("rnd%0d_latency", t), 64'(lat), 64'(LAT));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
